// File: rtl/ice51_pkg.sv
// ice51_pkg
// Shared definitions for the ice51 UART boot loader:
//   rx_state_t  - receiver FSM encoding (idle, start, data, stop, wait-high)
//   ld_state_t  - loader FSM encoding (load, run)
//   calc_cpb    - clocks per UART bit from clock frequency and baud rate
package ice51_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  typedef enum logic {
    LD_LOAD = 1'b0,
    LD_RUN  = 1'b1
  } ld_state_t;

  // Integer division: any remainder becomes a small, tolerated baud error.
  function automatic int calc_cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Start-bit sampling point sits half a bit after the falling edge.
  function automatic int calc_half_cpb(input int clk_hz, input int baud);
    return calc_cpb(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/ice51_uart_rx.sv
// ice51_uart_rx
// 8N1 LSB-first UART receiver with a two-flop input synchroniser.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   uart_rx      - asynchronous serial line, idle high
//   byte_valid   - one-cycle strobe when a frame with a good stop bit completes
//   byte_data    - received byte, held until the next good frame
//   frame_err    - one-cycle strobe when the stop bit samples low
module ice51_uart_rx
  import ice51_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CPB   = calc_cpb(CLK_HZ, BAUD);
  localparam int HALF  = calc_half_cpb(CLK_HZ, BAUD);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  logic            sync1;
  logic            sync2;
  rx_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  // Synchroniser flops reset to the idle level so reset release never looks
  // like a start bit. The stop bit is sampled at its centre and the FSM goes
  // straight back to IDLE, leaving half a bit to catch a back-to-back start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= uart_rx;
      sync2      <= sync1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!sync2) state <= RX_START;
        end
        RX_START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt <= '0;
            if (sync2) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_W'(CPB - 1)) begin
            cnt   <= '0;
            // Right shift: the first (LSB) bit ends up in bit 0 after eight.
            shift <= {sync2, shift[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_W'(CPB - 1)) begin
            cnt <= '0;
            if (sync2) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
              state      <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          cnt <= '0;
          if (sync2) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ice51_boot_loader.sv
// ice51_boot_loader
// Holds the ice51 core in reset while MEM_SIZE bytes arrive over the UART and
// are written to code memory from address 0, then releases the core and
// forwards further bytes to the core's serial peripheral.
// Ports:
//   i_clk, i_nrst           - clock, asynchronous active-low reset
//   i_uart_rx               - board UART RX pin
//   o_mem_we/addr/data      - code memory write port, one strobe per loaded byte
//   o_core_nrst             - core reset, low while loading
//   o_load_done             - high once the image is loaded
//   o_rx_valid / o_rx_data  - run-phase byte strobe and byte
//   o_frame_err             - one-cycle pulse on a bad stop bit
module ice51_boot_loader
  import ice51_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int BAUD     = 115200,
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 10,
  parameter bit PRELOAD  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_uart_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data,
  output logic              o_core_nrst,
  output logic              o_load_done,
  output logic              o_rx_valid,
  output logic [7:0]        o_rx_data,
  output logic              o_frame_err
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err;
  ld_state_t         ld_state;
  logic [ADDR_W-1:0] ptr;

  ice51_uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk        (i_clk),
    .rst_n      (i_nrst),
    .uart_rx    (i_uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // Core reset and load-done rise together with the final memory write, so
  // the core leaves reset only after the last byte is committed.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ld_state    <= PRELOAD ? LD_RUN : LD_LOAD;
      ptr         <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      o_rx_valid  <= 1'b0;
      o_rx_data   <= '0;
      o_frame_err <= 1'b0;
      o_core_nrst <= PRELOAD;
      o_load_done <= PRELOAD;
    end else begin
      o_mem_we    <= 1'b0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= frame_err;
      case (ld_state)
        LD_LOAD: begin
          if (byte_valid) begin
            o_mem_we   <= 1'b1;
            o_mem_addr <= ptr;
            o_mem_data <= byte_data;
            ptr        <= ptr + 1'b1;
            if (ptr == ADDR_W'(MEM_SIZE - 1)) begin
              ld_state    <= LD_RUN;
              o_core_nrst <= 1'b1;
              o_load_done <= 1'b1;
            end
          end
        end
        LD_RUN: begin
          if (byte_valid) begin
            o_rx_valid <= 1'b1;
            o_rx_data  <= byte_data;
          end
        end
        default: ld_state <= LD_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ice51_boot_loader.sv
// tb_ice51_boot_loader
// Directed bench for ice51_boot_loader with a short bit time (16 clocks) and a
// 32-byte image so full loads stay short.
module tb_ice51_boot_loader;

  localparam int CPB      = 16;
  localparam int MEM_SIZE = 32;
  localparam int ADDR_W   = 5;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              rx = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              core_nrst;
  logic              load_done;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              frame_err;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int weCount = 0;
  int weCoreHigh = 0;
  int lastAddr = -1;
  int lastData = -1;
  int lastWeCyc = 0;
  int rxCount = 0;
  int lastRx = -1;
  int feCount = 0;
  int coreHighCyc = 0;
  int startCyc = 0;

  ice51_boot_loader #(
    .CLK_HZ   (1843200),
    .BAUD     (115200),
    .MEM_SIZE (MEM_SIZE),
    .ADDR_W   (ADDR_W),
    .PRELOAD  (1'b0)
  ) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_uart_rx   (rx),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_data  (mem_data),
    .o_core_nrst (core_nrst),
    .o_load_done (load_done),
    .o_rx_valid  (rx_valid),
    .o_rx_data   (rx_data),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      weCount   = weCount + 1;
      lastAddr  = int'(mem_addr);
      lastData  = int'(mem_data);
      lastWeCyc = cyc;
      if (core_nrst === 1'b1) weCoreHigh = weCoreHigh + 1;
    end
    if (rx_valid === 1'b1) begin
      rxCount = rxCount + 1;
      lastRx  = int'(rx_data);
    end
    if (frame_err === 1'b1) feCount = feCount + 1;
    if (core_nrst === 1'b1) coreHighCyc = coreHighCyc + 1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
             tag, observed, observed, expected, expected);
    end
  endtask

  task automatic holdBit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one 8N1 frame; caller is aligned 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    startCyc = cyc;
    rx = 1'b0;
    holdBit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      holdBit();
    end
    rx = stopBit;
    holdBit();
    rx = 1'b1;
    if (!stopBit) idle(2 * CPB);
  endtask

  task automatic resetDut();
    nrst = 1'b0;
    rx   = 1'b1;
    idle(3);
    nrst = 1'b1;
    idle(2);
  endtask

  int baseWe, baseFe, baseRx, baseCore, baseWeCore;

  task automatic snapshot();
    baseWe     = weCount;
    baseFe     = feCount;
    baseRx     = rxCount;
    baseCore   = coreHighCyc;
    baseWeCore = weCoreHigh;
  endtask

  initial begin
    $display("[TB] starting ice51_boot_loader bench");
    nrst = 1'b0;
    idle(3);

    // Reset values while reset is held.
    checkOutput("rst_mem_we",    int'(mem_we),    0);
    checkOutput("rst_mem_addr",  int'(mem_addr),  0);
    checkOutput("rst_mem_data",  int'(mem_data),  0);
    checkOutput("rst_rx_valid",  int'(rx_valid),  0);
    checkOutput("rst_rx_data",   int'(rx_data),   0);
    checkOutput("rst_frame_err", int'(frame_err), 0);
    checkOutput("rst_core_nrst", int'(core_nrst), 0);
    checkOutput("rst_load_done", int'(load_done), 0);
    nrst = 1'b1;
    idle(4);

    // Single frame 0xA5: write at address 0 about 3 + CPB/2 + 9*CPB cycles on.
    snapshot();
    applyStimulus(8'hA5, 1'b1);
    idle(CPB);
    checkOutput("a5_we_count", weCount - baseWe, 1);
    checkOutput("a5_addr",     lastAddr, 0);
    checkOutput("a5_data",     lastData, 8'hA5);
    checkOutput("a5_latency_ok",
                int'((lastWeCyc - startCyc) >= 154 && (lastWeCyc - startCyc) <= 156), 1);
    checkOutput("a5_core_low", coreHighCyc - baseCore, 0);
    checkOutput("a5_load_done", int'(load_done), 0);

    // Short low glitch is ignored; the following frame lands at address 0.
    resetDut();
    snapshot();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * CPB);
    checkOutput("glitch_no_write", weCount - baseWe, 0);
    applyStimulus(8'h11, 1'b1);
    idle(CPB);
    checkOutput("glitch_we_count", weCount - baseWe, 1);
    checkOutput("glitch_addr",     lastAddr, 0);
    checkOutput("glitch_data",     lastData, 8'h11);
    checkOutput("glitch_no_ferr",  feCount - baseFe, 0);

    // Bad stop bit: one error pulse, byte dropped, next byte at address 0.
    resetDut();
    snapshot();
    applyStimulus(8'h55, 1'b0);
    checkOutput("ferr_count",    feCount - baseFe, 1);
    checkOutput("ferr_no_write", weCount - baseWe, 0);
    applyStimulus(8'h66, 1'b1);
    idle(CPB);
    checkOutput("ferr_we_count", weCount - baseWe, 1);
    checkOutput("ferr_addr",     lastAddr, 0);
    checkOutput("ferr_data",     lastData, 8'h66);
    checkOutput("ferr_no_rxv",   rxCount - baseRx, 0);

    // Ten bytes, then reset in the middle of a frame; reload restarts at 0.
    resetDut();
    snapshot();
    for (int i = 0; i < 10; i++) applyStimulus(8'(i + 8'h40), 1'b1);
    idle(CPB);
    checkOutput("ten_we_count", weCount - baseWe, 10);
    checkOutput("ten_last_addr", lastAddr, 9);
    checkOutput("ten_last_data", lastData, 8'h49);
    rx = 1'b0;
    idle(3 * CPB);
    nrst = 1'b0;
    rx = 1'b1;
    idle(1);
    checkOutput("midrst_addr", int'(mem_addr), 0);
    idle(2);
    nrst = 1'b1;
    idle(2 * CPB);
    applyStimulus(8'h77, 1'b1);
    idle(CPB);
    checkOutput("reload_we_count", weCount - baseWe, 11);
    checkOutput("reload_addr",     lastAddr, 0);
    checkOutput("reload_data",     lastData, 8'h77);
    checkOutput("reload_core_low", coreHighCyc - baseCore, 0);

    // Full image back to back; release coincides with the last write.
    resetDut();
    snapshot();
    for (int i = 0; i < MEM_SIZE; i++) applyStimulus(8'(i), 1'b1);
    idle(CPB);
    checkOutput("full_we_count",   weCount - baseWe, MEM_SIZE);
    checkOutput("full_last_addr",  lastAddr, MEM_SIZE - 1);
    checkOutput("full_last_data",  lastData, 8'h1F);
    checkOutput("full_core_at_last", weCoreHigh - baseWeCore, 1);
    checkOutput("full_core_nrst",  int'(core_nrst), 1);
    checkOutput("full_load_done",  int'(load_done), 1);

    // Run phase: bytes go to the rx strobe, never to memory.
    snapshot();
    applyStimulus(8'h3C, 1'b1);
    idle(CPB);
    checkOutput("run_rxv_count", rxCount - baseRx, 1);
    checkOutput("run_rx_last",   lastRx, 8'h3C);
    checkOutput("run_rx_data",   int'(rx_data), 8'h3C);
    checkOutput("run_no_write",  weCount - baseWe, 0);
    checkOutput("run_load_done", int'(load_done), 1);
    checkOutput("run_core_nrst", int'(core_nrst), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ice51_boot_loader.md
# ice51_boot_loader

UART boot loader sitting between the board UART RX pin and the ice51 core. After reset it holds the core in reset and receives exactly MEM_SIZE bytes, LSB-first 8N1. It writes them sequentially into code memory from address 0, then releases the core. In the run phase it forwards every further received byte to the core's serial peripheral as a one-cycle strobe.

## Interface
- CLK_HZ, 12000000, input clock frequency
- BAUD, 115200, line rate; CPB = CLK_HZ/BAUD (integer division, 104 at defaults)
- MEM_SIZE, 1024, bytes to load
- ADDR_W, 10, code memory address width; MEM_SIZE <= 2**ADDR_W
- PRELOAD, 0, 1 = memory already initialised; reset state is RUN
- i_clk  in  1  single clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_uart_rx  in  1  asynchronous serial input, idle high
- o_mem_we  out  1  code memory write strobe, one cycle per loaded byte
- o_mem_addr  out  ADDR_W  write address
- o_mem_data  out  8  write data
- o_core_nrst  out  1  core reset, low while loading
- o_load_done  out  1  high in RUN
- o_rx_valid  out  1  run-phase byte strobe, one cycle
- o_rx_data  out  8  run-phase byte, stable until next strobe
- o_frame_err  out  1  one-cycle pulse on bad stop bit

## Operation
- Input path: two-flop synchroniser on i_uart_rx; both flops reset to 1.
- Receiver FSM, states IDLE, START, DATA, STOP, WAIT_HIGH, all driven by a bit counter 0..CPB-1:
  - IDLE: synced line = 0 -> START, counter cleared.
  - START: at counter = CPB/2-1, sample. If 1 (glitch) -> IDLE. If 0 -> DATA, counter cleared, bit index 0.
  - DATA: at counter = CPB-1, shift sample into bit[index], LSB first. After index 7 -> STOP.
  - STOP: at counter = CPB-1, sample. If 1, pulse byte_valid -> IDLE. If 0, pulse o_frame_err, discard byte -> WAIT_HIGH.
  - WAIT_HIGH: stay until synced line = 1 -> IDLE.
- Loader FSM, states LOAD, RUN:
  - LOAD: each byte_valid -> o_mem_we=1, o_mem_data=byte, o_mem_addr=write pointer; pointer then increments. The write with pointer = MEM_SIZE-1 -> RUN.
  - RUN: o_load_done=1, o_core_nrst=1, o_mem_we never asserted. Each byte_valid -> o_rx_valid=1, o_rx_data=byte.
- Framing errors never advance the pointer and never produce o_rx_valid.
- Reset values: o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_rx_valid=0, o_rx_data=0, o_frame_err=0. With PRELOAD=0: o_core_nrst=0, o_load_done=0, loader in LOAD. With PRELOAD=1: o_core_nrst=1, o_load_done=1, loader in RUN.
- Reset asserted mid-operation: both FSMs, the pointer and the partial byte are cleared immediately. A reload restarts at address 0.

## Timing
- All outputs are registered.
- Start-bit falling edge at pin (cycle 0) -> IDLE sees low at cycle 2 -> byte_valid at cycle 2 + CPB/2 + 9*CPB (+/-1). That is 990 cycles at defaults.
- o_mem_we / o_rx_valid / o_frame_err assert one cycle after byte_valid.
- o_core_nrst and o_load_done rise in the same cycle as the last o_mem_we. The core leaves reset the cycle after that write completes.
- A low pulse shorter than CPB/2 - 2 cycles produces no byte and no error.
- Back-to-back frames with a single stop bit must be received: IDLE is re-entered at mid-stop-bit.

## Structure
- Shared package ice51_pkg holds the receiver and loader state encodings and the CPB/half-CPB derivation.
- Sub-module ice51_uart_rx contains the synchroniser, receiver FSM, byte_valid/byte/frame_err outputs.
- The loader FSM and write pointer live in ice51_boot_loader.

## Test plan
- Single frame 0xA5 after reset -> one o_mem_we with o_mem_addr=0, o_mem_data=0xA5, about 991 cycles after the start edge; o_core_nrst stays 0.
- 1024 frames 0x00..0xFF repeating -> last write has o_mem_addr=0x3FF, o_mem_data=0xFF. o_core_nrst and o_load_done go to 1 on that cycle and stay there.
- In RUN, send 0x3C -> o_rx_valid one cycle with o_rx_data=0x3C; o_mem_we stays 0.
- 20-cycle low glitch in LOAD, then frame 0x11 -> exactly one write with data 0x11 at address 0.
- Frame 0x55 with stop bit forced 0, then frame 0x66 -> o_frame_err pulses once. Only 0x66 is written, at address 0.
- Reset after 10 bytes loaded, then frame 0x77 -> write at address 0 with data 0x77; o_core_nrst low throughout.
